// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared widths and constants for the scoreboarded register file
package regfile_sb_pkg;

    localparam int REGBUS     = 64;
    localparam int REGADDRBUS = 5;
    localparam int NREGS      = 1 << REGADDRBUS;
    localparam int PCNT_W     = 2;

    localparam logic [REGBUS-1:0] ZEROWORD = '0;
    localparam logic              RSTENA   = 1'b1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

endpackage

// File: rtl/regfile_sb_cnt.sv
// rtl/regfile_sb_cnt.sv - saturating pending-writer counter for one architectural register
module regfile_sb_cnt
    import regfile_sb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic              dec,
    output logic [PCNT_W-1:0] cnt,
    output logic              ovf
);

    // Overflow only when a lone issue meets a saturated count; a matching writeback cancels it.
    always_comb begin
        ovf = inc && !dec && !clr && (cnt == PCNT_MAX);
    end

    // Count in-flight producers; clear beats issue, and issue+writeback together is a no-op.
    always_ff @(posedge clk) begin
        if (rst == RSTENA) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != PCNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 32x64 register file with writeback bypass and per-register pending scoreboard
module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_rd_ena,
    input  logic [REGADDRBUS-1:0] wb_rd_addr,
    input  logic [REGBUS-1:0]     wb_rd_data,
    input  logic                  rs1_ena,
    input  logic [REGADDRBUS-1:0] rs1_addr,
    input  logic                  rs2_ena,
    input  logic [REGADDRBUS-1:0] rs2_addr,
    output logic [REGBUS-1:0]     rs1_data,
    output logic [REGBUS-1:0]     rs2_data,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  iss_ena,
    input  logic [REGADDRBUS-1:0] iss_rd_addr,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  sb_ovf
);

    logic [REGBUS-1:0]            regs [NREGS];
    logic [NREGS-1:0][PCNT_W-1:0] cnt;
    logic [NREGS-1:0]             ovf_vec;
    logic                         wb_live;

    assign wb_live    = wb_rd_ena && (wb_rd_addr != '0);
    assign cnt[0]     = '0;
    assign ovf_vec[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cnt
        regfile_sb_cnt u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .inc (iss_ena && (iss_rd_addr == REGADDRBUS'(i))),
            .dec (wb_rd_ena && (wb_rd_addr == REGADDRBUS'(i))),
            .cnt (cnt[i]),
            .ovf (ovf_vec[i])
        );
    end

    // Register storage; x0 is held at zero and never written, writeback data survives a flush.
    always_ff @(posedge clk) begin
        if (rst == RSTENA) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= ZEROWORD;
            end
        end else if (wb_live) begin
            regs[wb_rd_addr] <= wb_rd_data;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst == RSTENA) begin
            sb_ovf <= 1'b0;
        end else if (|ovf_vec) begin
            sb_ovf <= 1'b1;
        end
    end

    // Read ports with same-cycle writeback bypass; a writeback retiring the last producer frees the source.
    always_comb begin
        rs1_data = ZEROWORD;
        rs2_data = ZEROWORD;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1_ena && (rs1_addr != '0)) begin
            rs1_data = (wb_live && (wb_rd_addr == rs1_addr)) ? wb_rd_data : regs[rs1_addr];
            rs1_busy = (cnt[rs1_addr] != '0) &&
                       !(wb_live && (wb_rd_addr == rs1_addr) && (cnt[rs1_addr] == PCNT_W'(1)));
        end
        if (rs2_ena && (rs2_addr != '0)) begin
            rs2_data = (wb_live && (wb_rd_addr == rs2_addr)) ? wb_rd_data : regs[rs2_addr];
            rs2_busy = (cnt[rs2_addr] != '0) &&
                       !(wb_live && (wb_rd_addr == rs2_addr) && (cnt[rs2_addr] == PCNT_W'(1)));
        end
        hazard_stall = rs1_busy || rs2_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed self-checking bench for regfile_sb
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_rd_ena;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_rd_data;
    logic        rs1_ena, rs2_ena;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        iss_ena;
    logic [4:0]  iss_rd_addr;
    logic        flush;
    logic        hazard_stall;
    logic        sb_ovf;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [63:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_ovf;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk          (clk),
        .rst          (rst),
        .wb_rd_ena    (wb_rd_ena),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_data   (wb_rd_data),
        .rs1_ena      (rs1_ena),
        .rs1_addr     (rs1_addr),
        .rs2_ena      (rs2_ena),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .iss_ena      (iss_ena),
        .iss_rd_addr  (iss_rd_addr),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .sb_ovf       (sb_ovf)
    );

    function automatic bit wb_hits(input logic [4:0] a);
        return wb_rd_ena && (wb_rd_addr != 0) && (wb_rd_addr == a);
    endfunction

    function automatic logic [63:0] exp_data(input logic ena, input logic [4:0] a);
        if (!ena || a == 0) return 64'd0;
        if (wb_hits(a)) return wb_rd_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic ena, input logic [4:0] a);
        if (!ena || a == 0) return 1'b0;
        if (m_cnt[a] == 0) return 1'b0;
        return !(wb_hits(a) && m_cnt[a] == 1);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference model across one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 64'd0;
                m_cnt[r]  = 0;
            end
            m_ovf = 1'b0;
            return;
        end
        if (wb_rd_ena && wb_rd_addr != 0) m_regs[wb_rd_addr] = wb_rd_data;
        for (int r = 1; r < 32; r++) begin
            bit up   = iss_ena && (iss_rd_addr == r);
            bit down = wb_rd_ena && (wb_rd_addr == r);
            if (flush) begin
                m_cnt[r] = 0;
            end else if (up && !down) begin
                if (m_cnt[r] == 3) m_ovf = 1'b1;
                else m_cnt[r] = m_cnt[r] + 1;
            end else if (down && !up && m_cnt[r] > 0) begin
                m_cnt[r] = m_cnt[r] - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        check_en = 1'b1;
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        wb_rd_ena = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
        iss_ena = 1'b0; iss_rd_addr = '0;
        rs1_ena = 1'b0; rs1_addr = '0; rs2_ena = 1'b0; rs2_addr = '0;
    endtask

    // Compare every DUT output against the model midway through each cycle.
    always @(negedge clk) begin
        if (check_en) begin
            logic eb1, eb2;
            eb1 = exp_busy(rs1_ena, rs1_addr);
            eb2 = exp_busy(rs2_ena, rs2_addr);
            cmp("rs1_data", rs1_data, exp_data(rs1_ena, rs1_addr));
            cmp("rs2_data", rs2_data, exp_data(rs2_ena, rs2_addr));
            cmp("rs1_busy", 64'(rs1_busy), 64'(eb1));
            cmp("rs2_busy", 64'(rs2_busy), 64'(eb2));
            cmp("hazard_stall", 64'(hazard_stall), 64'(eb1 | eb2));
            cmp("sb_ovf", 64'(sb_ovf), 64'(m_ovf));
        end
    end

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 64'd0;
            m_cnt[r]  = 0;
        end
        m_ovf = 1'b0;
        idle();
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        idle();
        rs1_ena = 1; rs1_addr = 5; rs2_ena = 1; rs2_addr = 31;
        #3;
        cmp("lit_rst_rs1_data", rs1_data, 64'd0);
        cmp("lit_rst_rs2_data", rs2_data, 64'd0);
        cmp("lit_rst_busy", 64'({rs1_busy, rs2_busy, hazard_stall}), 64'd0);
        cmp("lit_rst_ovf", 64'(sb_ovf), 64'd0);
        tick();

        // Bypass then storage read of x3
        idle();
        wb_rd_ena = 1; wb_rd_addr = 3; wb_rd_data = 64'hDEAD_BEEF_0000_0001;
        rs1_ena = 1; rs1_addr = 3;
        #3 cmp("lit_bypass_x3", rs1_data, 64'hDEAD_BEEF_0000_0001);
        tick();
        idle(); rs1_ena = 1; rs1_addr = 3;
        #3 cmp("lit_storage_x3", rs1_data, 64'hDEAD_BEEF_0000_0001);
        tick();

        // x0 is never written nor pending
        idle();
        wb_rd_ena = 1; wb_rd_addr = 0; wb_rd_data = '1;
        iss_ena = 1; iss_rd_addr = 0; rs1_ena = 1; rs1_addr = 0;
        #3 cmp("lit_x0_bypass", rs1_data, 64'd0);
        tick();
        idle(); rs1_ena = 1; rs1_addr = 0;
        #3 cmp("lit_x0_data", rs1_data, 64'd0);
        cmp("lit_x0_busy", 64'(rs1_busy), 64'd0);
        tick();

        // Two producers of x7
        idle(); iss_ena = 1; iss_rd_addr = 7; tick();
        idle(); iss_ena = 1; iss_rd_addr = 7; tick();
        idle(); wb_rd_ena = 1; wb_rd_addr = 7; wb_rd_data = 64'h77; tick();
        idle(); rs1_ena = 1; rs1_addr = 7;
        #3 cmp("lit_x7_busy_one_left", 64'(rs1_busy), 64'd1);
        wb_rd_ena = 1; wb_rd_addr = 7; wb_rd_data = 64'h78;
        #0 cmp("lit_x7_busy_last_wb", 64'(rs1_busy), 64'd0);
        tick();

        // Issue and writeback together on x9, then saturation
        idle(); iss_ena = 1; iss_rd_addr = 9; tick();
        idle(); iss_ena = 1; iss_rd_addr = 9; wb_rd_ena = 1; wb_rd_addr = 9; wb_rd_data = 64'h99; tick();
        idle(); rs1_ena = 1; rs1_addr = 9;
        #3 cmp("lit_x9_still_busy", 64'(rs1_busy), 64'd1);
        wb_rd_ena = 1; wb_rd_addr = 9; wb_rd_data = 64'h9A;
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(); iss_ena = 1; iss_rd_addr = 9; tick();
        end
        idle();
        #3 cmp("lit_x9_ovf_before", 64'(sb_ovf), 64'd0);
        iss_ena = 1; iss_rd_addr = 9; tick();
        idle();
        #3 cmp("lit_x9_ovf_after", 64'(sb_ovf), 64'd1);

        // Flush discards pending x4/x5 and same-cycle issue of x6
        idle(); iss_ena = 1; iss_rd_addr = 4; tick();
        idle(); iss_ena = 1; iss_rd_addr = 5; tick();
        idle(); flush = 1; iss_ena = 1; iss_rd_addr = 6; tick();
        idle(); rs1_ena = 1; rs1_addr = 4; rs2_ena = 1; rs2_addr = 6;
        #3 cmp("lit_flush_x4", 64'(rs1_busy), 64'd0);
        cmp("lit_flush_x6", 64'(rs2_busy), 64'd0);
        tick();
        idle(); wb_rd_ena = 1; wb_rd_addr = 4; wb_rd_data = 64'h1234; tick();
        idle(); rs1_ena = 1; rs1_addr = 4;
        #3 cmp("lit_x4_data_after_flush", rs1_data, 64'h1234);
        cmp("lit_x4_busy_after_flush", 64'(rs1_busy), 64'd0);
        tick();

        // Reset in the middle of activity
        idle(); iss_ena = 1; iss_rd_addr = 12; wb_rd_ena = 1; wb_rd_addr = 3; wb_rd_data = 64'h5; tick();
        idle(); rst = 1; iss_ena = 1; iss_rd_addr = 12; wb_rd_ena = 1; wb_rd_addr = 12; wb_rd_data = 64'hAB; tick();
        idle(); rs1_ena = 1; rs1_addr = 12; rs2_ena = 1; rs2_addr = 3;
        #3 cmp("lit_midrst_x12", rs1_data, 64'd0);
        cmp("lit_midrst_x3", rs2_data, 64'd0);
        cmp("lit_midrst_ovf", 64'(sb_ovf), 64'd0);
        tick();

        // Randomized traffic with a narrow address window to force collisions
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            wb_rd_ena   = ($urandom_range(0, 2) != 0);
            wb_rd_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wb_rd_data  = {$urandom, $urandom};
            iss_ena     = ($urandom_range(0, 1) != 0);
            iss_rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs1_ena     = ($urandom_range(0, 4) != 0);
            rs1_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs2_ena     = ($urandom_range(0, 4) != 0);
            rs2_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            tick();
        end

        idle();
        tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
